if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Fetch-stage producer feeding the IF/ID pipeline register (pc, instruction, freeze, flush).
//  Holds the fetch PC and issues single-outstanding requests to instruction memory over a req/ack handshake.
//  Buffers returned words in a small prefetch FIFO, and presents {pc+4, instruction, valid} to IF/ID.
//  Honours hazard-unit freeze; an EX-stage branch redirects fetch and discards stale data.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch address after reset
//  FIFO_DEPTH  2              prefetch entries, power of two, >=2
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   reset, synchronous, active-low
//  freeze         in   1   hazard stall; head entry held, no pop
//  branch_taken   in   1   redirect request from EX
//  branch_addr    in   32  redirect target (word aligned)
//  imem_req       out  1   memory request valid
//  imem_addr      out  32  request address
//  imem_ack       in   1   response valid; rdata valid same cycle
//  imem_rdata     in   32  instruction word
//  pc_out         out  32  pc+4 of head instruction (to IF/ID pc_in)
//  instruction_out out 32  head instruction (to IF/ID instruction_in)
//  valid_out      out  1   head valid; 0 -> IF/ID must load bubble
//  perf_fetched   out  32  retired-fetch counter (FETCH_PERF_EN)
//  perf_stalls    out  32  freeze-cycle counter (FETCH_PERF_EN)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): fetch_pc=RESET_PC, FIFO empty, state IDLE; all outputs 0.
//  - FSM: IDLE -> REQ when FIFO occupancy < FIFO_DEPTH and !branch_taken; REQ -> IDLE on imem_ack;
//    REQ -> DROP on branch_taken without ack; REQ+ack+branch_taken -> IDLE, data discarded; DROP -> IDLE on imem_ack (data discarded).
//  - imem_req=1 and imem_addr=fetch_pc only in REQ; both held stable until ack (never drop req mid-handshake).
//  - Ack in REQ: push {fetch_pc+4, imem_rdata}; fetch_pc += 4 (mod 2^32, wraps silently).
//  - Minimum latency: request to valid_out = 1 cycle after ack (FIFO registered).
//  - Pop when valid_out && !freeze; push and pop in same cycle allowed when full (occupancy unchanged).
//  - Full: no new request launched; an already-outstanding request always has a free slot (reserved at issue).
//  - branch_taken (priority over freeze, ack, pop): FIFO cleared, fetch_pc=branch_addr, valid_out=0 next cycle.
//  - Empty: valid_out=0, pc_out/instruction_out=0.
//  - rst mid-REQ: state forced IDLE; a late ack is ignored in IDLE (memory must tolerate abandoned request).
// CONFIGURATION
//  FETCH_PERF_EN defined: perf_fetched +1 per pop, perf_stalls +1 per cycle freeze&&valid_out;
//    both reset to 0, wrap at 2^32, do not count while rst low.
//  FETCH_PERF_EN undefined: counters not built, perf_* tied to 0.
// STRUCTURE
//  Package if_fetch_pkg: fetch_state_t enum {IDLE, REQ, DROP}; INSTR_W=32; PC_STEP=4; fetch_entry_t {pc, instr}.
//  Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, depth FIFO_DEPTH, push/pop/clear, count, full/empty.
//  Top holds PC register, FSM, outstanding reservation, perf counters.
// TESTING
//  1 Reset release, imem_ack one cycle after every req -> imem_addr 0,4,8...; first valid_out with pc_out=4, instruction_out=word@0.
//  2 freeze high 5 cycles from cycle 10 -> outputs held, FIFO fills to 2, imem_req low while full; release -> pops resume in order.
//  3 branch_taken=1, branch_addr=0x100 while REQ pending -> DROP, stale ack discarded, next imem_addr=0x100, next valid pc_out=0x104.
//  4 branch_taken coincident with imem_ack and freeze -> FIFO empty next cycle, fetch_pc=branch_addr, no push.
//  5 rst low mid-REQ, ack arrives during reset/IDLE -> ignored; restart fetch at RESET_PC.
//  6 FETCH_PERF_EN: 20 pops, 7 frozen-valid cycles -> perf_fetched=20, perf_stalls=7; without macro both 0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t : request FSM states (IDLE, REQ, DROP)
//   fetch_entry_t : one prefetched word, {pc of next instruction, instruction}
package if_fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer built as a shift register: entry 0 is always the head, so the
// head word and its valid flag come straight from flops. Empty slots hold zero,
// which makes an empty FIFO present an all-zero head.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   push_i/wdata_i: append an entry (accepted when not full, or full with a pop)
//   pop_i         : drop the head (ignored when empty)
//   clear_i       : discard all entries; dominates push and pop
//   rdata_o       : head entry (zero when empty)
//   count_o       : occupancy
//   empty_o       : no valid head
module fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  fetch_entry_t             wdata_i,
    output fetch_entry_t             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q;
    logic             do_pop, do_push;

    assign do_pop  = pop_i && valid_q;
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Next contents: shift down on pop, then write at the first free slot.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (clear_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_d[i] = '0;
            end
            count_d = '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    mem_d[i] = mem_q[PTR_W'(i + 1)];
                end
                mem_d[DEPTH-1] = '0;
                count_d        = count_q - CNT_W'(1);
            end
            if (do_push) begin
                mem_d[count_d[PTR_W-1:0]] = wdata_i;
                count_d                   = count_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    assign rdata_o = mem_q[0];
    assign count_o = count_q;
    assign empty_o = !valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the fetch PC, runs a single-outstanding req/ack handshake to
// instruction memory, buffers returned words and presents the head to IF/ID.
// Optional macro FETCH_PERF_EN builds the pop and frozen-cycle counters;
// without it perf_fetched/perf_stalls are tied to zero.
// Ports:
//   clk, rst                         : clock, synchronous active-low reset
//   freeze                           : hold the head entry (no pop)
//   branch_taken, branch_addr        : redirect; flushes buffered and in-flight data
//   imem_req, imem_addr              : request, held stable until imem_ack
//   imem_ack, imem_rdata             : response, data valid with ack
//   pc_out, instruction_out, valid_out : head entry towards IF/ID (zero when empty)
//   perf_fetched, perf_stalls        : performance counters
module if_fetch_unit
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    state_q;
    logic [PC_W-1:0] fetch_pc_q;
    logic            req_q;
    logic [PC_W-1:0] addr_q;

    fetch_entry_t     push_entry, head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty, fifo_full;
    logic             take_ack, pop;

    // A response is kept only if it answers a live request and no redirect wins.
    assign take_ack  = (state_q == REQ) && imem_ack && !branch_taken;
    assign pop       = valid_out && !freeze && !branch_taken;
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));

    assign push_entry.pc    = fetch_pc_q + PC_STEP;
    assign push_entry.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (take_ack),
        .pop_i   (pop),
        .clear_i (branch_taken),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    // Request FSM and fetch PC. A request is only issued with a free slot, and
    // nothing else can fill that slot while it is outstanding, so the response
    // always fits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!branch_taken && !fifo_full) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        addr_q  <= '0;
                    end else if (branch_taken) begin
                        // Memory still owes a response; wait for it and throw it away.
                        state_q <= DROP;
                        req_q   <= 1'b0;
                        addr_q  <= '0;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    addr_q  <= '0;
                end
            endcase

            if (branch_taken) begin
                fetch_pc_q <= branch_addr;
            end else if (take_ack) begin
                fetch_pc_q <= fetch_pc_q + PC_STEP;
            end
        end
    end

    assign imem_req        = req_q;
    assign imem_addr       = addr_q;
    assign pc_out          = head.pc;
    assign instruction_out = head.instr;
    assign valid_out       = !fifo_empty;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stalls_q;

    // Retired fetches and cycles where a valid head is held by freeze.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_stalls_q  <= '0;
        end else begin
            if (pop) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (freeze && valid_out) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stalls  = perf_stalls_q;
`else
    assign perf_fetched = '0;
    assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit. The stimulus process plays the memory and
// the hazard/branch sources and pushes every instruction that must reach IF/ID
// into exp_q; a separate monitor on the falling edge compares the head and pops.
module tb_if_fetch_unit;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, freeze, branch_taken, imem_req, imem_ack, valid_out;
    logic [31:0] branch_addr, imem_addr, imem_rdata, pc_out, instruction_out;
    logic [31:0] perf_fetched, perf_stalls;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out),
        .perf_fetched    (perf_fetched),
        .perf_stalls     (perf_stalls)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    bit          pend, pcanc, pushed_now, prev_rst, started;
    logic [31:0] paddr;
    int          pwait, lat;
    logic [31:0] m_fetched, m_stalls;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a3c_9e17;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: memory model, redirect/freeze/reset, expected stream.
    task automatic step(input logic fz, input logic br, input logic [31:0] ba,
                        input logic rs, input bit stale);
        logic        ack, br_eff, deliver;
        logic [31:0] rd;
        @(posedge clk);
        #2;
        ack     = 1'b0;
        rd      = $urandom;
        deliver = 1'b0;
        if (!prev_rst) begin
            check("rst_req", 32'(imem_req), 32'd0);
            check("rst_addr", imem_addr, 32'd0);
            check("rst_valid", 32'(valid_out), 32'd0);
        end else if (pend) begin
            if (pcanc) begin
                check("drop_req", 32'(imem_req), 32'd0);
            end else begin
                check("hold_req", 32'(imem_req), 32'd1);
                check("hold_addr", imem_addr, paddr);
            end
        end else if (exp_q.size() == DEPTH) begin
            check("full_noreq", 32'(imem_req), 32'd0);
        end
        if (rs && prev_rst && !pend && imem_req === 1'b1) begin
            check("req_addr", imem_addr, exp_pc);
            pend  = 1'b1;
            pcanc = 1'b0;
            paddr = imem_addr;
            pwait = lat;
        end
        if (pend) begin
            if (pwait == 0) begin
                ack     = 1'b1;
                rd      = memf(paddr);
                pend    = 1'b0;
                deliver = !pcanc;
            end else begin
                pwait--;
            end
        end else if (stale) begin
            ack = 1'b1;
        end
        br_eff = br && rs;
        if (!rs) begin
            exp_q.delete();
            exp_pc  = RST_PC;
            pcanc   = 1'b1;
            deliver = 1'b0;
        end else if (br_eff) begin
            exp_q.delete();
            exp_pc  = ba;
            pcanc   = 1'b1;
            deliver = 1'b0;
        end
        if (deliver) begin
            exp_q.push_back({exp_pc + 32'd4, memf(exp_pc)});
            exp_pc = exp_pc + 32'd4;
        end
        pushed_now   = deliver;
        freeze       = fz;
        branch_taken = br_eff;
        branch_addr  = ba;
        rst          = rs;
        imem_ack     = ack;
        imem_rdata   = rd;
        prev_rst     = rs;
    endtask

    task automatic wait_pending(input int w);
        int k;
        k = 0;
        while (!(pend && !pcanc && pwait == w) && k < 20) begin
            step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            k++;
        end
        if (k >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_pending: no outstanding request within 20 cycles");
        end
    endtask

    // Monitor: compares the presented head against the scoreboard and pops on retire.
    always @(negedge clk) begin
        logic [31:0] ef, es;
        int          committed;
        if (started) begin
`ifdef FETCH_PERF_EN
            ef = m_fetched;
            es = m_stalls;
`else
            ef = 32'd0;
            es = 32'd0;
`endif
            check("perf_fetched", perf_fetched, ef);
            check("perf_stalls", perf_stalls, es);
            if (valid_out !== 1'b1) begin
                check("empty_pc", pc_out, 32'd0);
                check("empty_instr", instruction_out, 32'd0);
            end
            if (rst && !branch_taken) begin
                committed = exp_q.size() - int'(pushed_now);
                check("valid_out", 32'(valid_out), 32'(committed > 0));
                if (valid_out === 1'b1 && committed > 0) begin
                    check("head_pc", pc_out, exp_q[0][63:32]);
                    check("head_instr", instruction_out, exp_q[0][31:0]);
                    if (!freeze) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (!rst) begin
                m_fetched = 32'd0;
                m_stalls  = 32'd0;
            end else begin
                if (valid_out && freeze) m_stalls = m_stalls + 32'd1;
                if (valid_out && !freeze && !branch_taken) m_fetched = m_fetched + 32'd1;
            end
        end
    end

    initial begin
        logic [31:0] ba;
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'd0;
        exp_pc       = RST_PC;
        lat          = 1;
        pend         = 1'b0;
        pcanc        = 1'b0;
        pushed_now   = 1'b0;
        prev_rst     = 1'b0;
        m_fetched    = 32'd0;
        m_stalls     = 32'd0;
        repeat (2) @(posedge clk);
        started = 1'b1;

        // Reset held, then streaming with ack one cycle after each request.
        repeat (2) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        repeat (16) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Freeze for 5 cycles: buffer fills and requests stop, then drains in order.
        repeat (5) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Redirect while a request is outstanding; its response must be dropped.
        lat = 2;
        wait_pending(1);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Redirect on the same cycle as ack and freeze.
        lat = 1;
        repeat (4) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        wait_pending(0);
        step(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Fetch PC wrapping past 2^32.
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
        repeat (14) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Reset in the middle of a request, then a stray ack in the first idle cycle.
        lat = 2;
        wait_pending(1);
        repeat (4) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            lat = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) begin
                ba = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 32'd4);
            end else begin
                ba = $urandom & 32'hFFFF_FFFC;
            end
            if ($urandom_range(0, 499) == 0) begin
                repeat (4) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            end else begin
                step(1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 4),
                     ba, 1'b1, 1'b0);
            end
        end
        repeat (6) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
